rect_motion_ctrl: RTL and testbench

//  Per-frame animation controller for the two-rectangle video generator (main 56px red, secondary 28px blue).

---
 rtl/rect_motion_ctrl_if.sv | 25 ++
 rtl/rect_motion_ctrl.sv | 127 ++++++++++++
 tb/tb_rect_motion_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rect_motion_ctrl_if.sv
// Control and rectangle-state bundle between the frame sequencer and the
// motion controller.
interface rect_motion_ctrl_if;
    logic       frame_start;
    logic       run;
    logic       step_btn;
    logic       swap_req;
    logic [9:0] main_x;
    logic [9:0] main_y;
    logic [9:0] sec_x;
    logic [9:0] sec_y;
    logic       main_on_top;
    logic       collide;
    logic [7:0] hit_count;
    logic       busy;

    modport master (
        output frame_start, run, step_btn, swap_req,
        input  main_x, main_y, sec_x, sec_y, main_on_top, collide, hit_count, busy
    );
    modport slave (
        input  frame_start, run, step_btn, swap_req,
        output main_x, main_y, sec_x, sec_y, main_on_top, collide, hit_count, busy
    );
endinterface

// File: rtl/rect_motion_ctrl.sv
// Per-frame motion of two bouncing rectangles, updated during vertical blanking,
// with overlap detection, hit counting and draw-priority control.
module rect_motion_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int MAIN_SIZE = 56,
    parameter int SEC_SIZE  = 28,
    parameter int STEP      = 2,
    parameter int MAIN_X0   = 60,
    parameter int MAIN_Y0   = 30,
    parameter int SEC_X0    = 420,
    parameter int SEC_Y0    = 300
) (
    input  logic              clk,
    input  logic              rst_n,
    rect_motion_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UPD_MAIN, UPD_SEC, CHECK} state_t;

    // neg=1 means the axis is currently moving towards 0
    typedef struct packed {
        logic [9:0] pos;
        logic       neg;
    } axis_t;

    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam logic signed [11:0] H_LIM  = 12'(H_ACTIVE);
    localparam logic signed [11:0] V_LIM  = 12'(V_ACTIVE);
    localparam logic signed [11:0] MAIN_S = 12'(MAIN_SIZE);
    localparam logic signed [11:0] SEC_S  = 12'(SEC_SIZE);

    function automatic axis_t axis_upd(input axis_t a, input logic signed [11:0] size,
                                       input logic signed [11:0] lim);
        logic signed [11:0] nxt;
        axis_t r;
        nxt = a.neg ? $signed({2'b00, a.pos}) - STEP_S : $signed({2'b00, a.pos}) + STEP_S;
        r = a;
        if (nxt < 12'sd0) begin
            r.pos = '0;
            r.neg = ~a.neg;
        end else if (nxt + size > lim) begin
            r.pos = 10'(lim - size);
            r.neg = ~a.neg;
        end else begin
            r.pos = nxt[9:0];
        end
        return r;
    endfunction

    state_t     state, state_nxt;
    axis_t      mx, my, sx, sy;
    logic       main_on_top_q, collide_q, step_pend, swap_pend;
    logic [7:0] hit_q;
    logic       ov;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.frame_start && (bus.run || step_pend)) state_nxt = UPD_MAIN;
            UPD_MAIN: state_nxt = UPD_SEC;
            UPD_SEC:  state_nxt = CHECK;
            CHECK:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Overlap is evaluated on the freshly updated origins, so it is only
    // meaningful in CHECK.
    always_comb begin
        ov = ({1'b0, mx.pos} < {1'b0, sx.pos} + 11'(SEC_SIZE))  &&
             ({1'b0, sx.pos} < {1'b0, mx.pos} + 11'(MAIN_SIZE)) &&
             ({1'b0, my.pos} < {1'b0, sy.pos} + 11'(SEC_SIZE))  &&
             ({1'b0, sy.pos} < {1'b0, my.pos} + 11'(MAIN_SIZE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mx            <= '{10'(MAIN_X0), 1'b0};
            my            <= '{10'(MAIN_Y0), 1'b0};
            sx            <= '{10'(SEC_X0), 1'b1};
            sy            <= '{10'(SEC_Y0), 1'b1};
            main_on_top_q <= 1'b1;
            collide_q     <= 1'b0;
            hit_q         <= '0;
            step_pend     <= 1'b0;
            swap_pend     <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt == UPD_MAIN) step_pend <= 1'b0;
            else if (bus.step_btn && !bus.run)          step_pend <= 1'b1;

            // A swap request landing in CHECK is held over for the next update
            if (state == CHECK) swap_pend <= bus.swap_req;
            else                swap_pend <= swap_pend | bus.swap_req;

            case (state)
                UPD_MAIN: begin
                    mx <= axis_upd(mx, MAIN_S, H_LIM);
                    my <= axis_upd(my, MAIN_S, V_LIM);
                end
                UPD_SEC: begin
                    sx <= axis_upd(sx, SEC_S, H_LIM);
                    sy <= axis_upd(sy, SEC_S, V_LIM);
                end
                CHECK: begin
                    main_on_top_q <= main_on_top_q ^ swap_pend;
                    collide_q     <= ov;
                    if (ov && !collide_q && hit_q != 8'hFF) hit_q <= hit_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.main_x      = mx.pos;
    assign bus.main_y      = my.pos;
    assign bus.sec_x       = sx.pos;
    assign bus.sec_y       = sy.pos;
    assign bus.main_on_top = main_on_top_q;
    assign bus.collide     = collide_q;
    assign bus.hit_count   = hit_q;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_rect_motion_ctrl.sv
// Directed bench for rect_motion_ctrl: default geometry, a wall-bounce
// instance and an overlapping instance, all driven from shared inputs.
module tb_rect_motion_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0, run = 1'b0, step_btn = 1'b0, swap_req = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rect_motion_ctrl_if bus0();
    rect_motion_ctrl_if bus_e();
    rect_motion_ctrl_if bus_o();

    assign bus0.frame_start  = frame_start;
    assign bus0.run          = run;
    assign bus0.step_btn     = step_btn;
    assign bus0.swap_req     = swap_req;
    assign bus_e.frame_start = frame_start;
    assign bus_e.run         = run;
    assign bus_e.step_btn    = step_btn;
    assign bus_e.swap_req    = swap_req;
    assign bus_o.frame_start = frame_start;
    assign bus_o.run         = run;
    assign bus_o.step_btn    = step_btn;
    assign bus_o.swap_req    = swap_req;

    rect_motion_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus0));
    rect_motion_ctrl #(.MAIN_X0(582), .SEC_X0(2)) dut_e (.clk(clk), .rst_n(rst_n), .bus(bus_e));
    rect_motion_ctrl #(.MAIN_X0(400), .MAIN_Y0(300), .SEC_X0(440), .SEC_Y0(310))
        dut_o (.clk(clk), .rst_n(rst_n), .bus(bus_o));

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; frame_start = 1'b0; run = 1'b0; step_btn = 1'b0; swap_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Pulse frame_start, then wait until the whole update has settled
    task automatic frame();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus0.main_x, bus0.main_y, bus0.sec_x, bus0.sec_y} !== {10'd60, 10'd30, 10'd420, 10'd300}) begin
            failures++;
            $display("FAIL reset_origin got=(%0d,%0d)(%0d,%0d) exp=(60,30)(420,300)",
                     bus0.main_x, bus0.main_y, bus0.sec_x, bus0.sec_y);
        end
        checks++;
        if ({bus0.main_on_top, bus0.collide, bus0.hit_count, bus0.busy} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_flags got top=%b col=%b hit=%0d busy=%b exp 1 0 0 0",
                     bus0.main_on_top, bus0.collide, bus0.hit_count, bus0.busy);
        end
        run = 1'b1;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.main_x !== 10'd62) begin
            failures++;
            $display("FAIL reset_pre_main_x got=%0d exp=62", bus0.main_x);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus0.main_x, bus0.main_y, bus0.sec_x, bus0.sec_y, bus0.main_on_top, bus0.busy} !==
            {10'd60, 10'd30, 10'd420, 10'd300, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_upd got=(%0d,%0d)(%0d,%0d) top=%b busy=%b exp=(60,30)(420,300) 1 0",
                     bus0.main_x, bus0.main_y, bus0.sec_x, bus0.sec_y, bus0.main_on_top, bus0.busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({bus0.main_x, bus0.sec_x, bus0.busy, bus0.collide} !== {10'd60, 10'd420, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_no_partial got main_x=%0d sec_x=%0d busy=%b col=%b exp 60 420 0 0",
                     bus0.main_x, bus0.sec_x, bus0.busy, bus0.collide);
        end
        run = 1'b0;
    endtask

    task automatic test_update();
        do_reset();
        run = 1'b1;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        checks++;
        if ({bus0.busy, bus0.main_x, bus0.main_y} !== {1'b1, 10'd60, 10'd30}) begin
            failures++;
            $display("FAIL upd_n1 got busy=%b main=(%0d,%0d) exp 1 (60,30)", bus0.busy, bus0.main_x, bus0.main_y);
        end
        @(negedge clk);
        checks++;
        if ({bus0.busy, bus0.main_x, bus0.main_y, bus0.sec_x, bus0.sec_y} !==
            {1'b1, 10'd62, 10'd32, 10'd420, 10'd300}) begin
            failures++;
            $display("FAIL upd_n2 got busy=%b main=(%0d,%0d) sec=(%0d,%0d) exp 1 (62,32) (420,300)",
                     bus0.busy, bus0.main_x, bus0.main_y, bus0.sec_x, bus0.sec_y);
        end
        @(negedge clk);
        checks++;
        if ({bus0.busy, bus0.sec_x, bus0.sec_y} !== {1'b1, 10'd418, 10'd298}) begin
            failures++;
            $display("FAIL upd_n3 got busy=%b sec=(%0d,%0d) exp 1 (418,298)", bus0.busy, bus0.sec_x, bus0.sec_y);
        end
        @(negedge clk);
        checks++;
        if (bus0.busy !== 1'b0) begin
            failures++;
            $display("FAIL upd_n4_busy got=%b exp=0", bus0.busy);
        end
        run = 1'b0;
    endtask

    task automatic test_wall_bounce();
        do_reset();
        run = 1'b1;
        frame();
        checks++;
        if ({bus_e.main_x, bus_e.sec_x} !== {10'd584, 10'd0}) begin
            failures++;
            $display("FAIL wall_f1 got main_x=%0d sec_x=%0d exp 584 0", bus_e.main_x, bus_e.sec_x);
        end
        frame();
        checks++;
        if ({bus_e.main_x, bus_e.sec_x} !== {10'd584, 10'd0}) begin
            failures++;
            $display("FAIL wall_f2 got main_x=%0d sec_x=%0d exp 584 0", bus_e.main_x, bus_e.sec_x);
        end
        frame();
        checks++;
        if ({bus_e.main_x, bus_e.main_y, bus_e.sec_x, bus_e.sec_y} !== {10'd582, 10'd36, 10'd2, 10'd294}) begin
            failures++;
            $display("FAIL wall_f3 got main=(%0d,%0d) sec=(%0d,%0d) exp (582,36) (2,294)",
                     bus_e.main_x, bus_e.main_y, bus_e.sec_x, bus_e.sec_y);
        end
        run = 1'b0;
    endtask

    task automatic test_step();
        do_reset();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        checks++;
        if (bus0.busy !== 1'b0) begin
            failures++;
            $display("FAIL step_idle_busy got=%b exp=0", bus0.busy);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus0.main_x !== 10'd60) begin
            failures++;
            $display("FAIL step_no_run got main_x=%0d exp=60", bus0.main_x);
        end
        @(negedge clk) step_btn = 1'b1;
        @(negedge clk) step_btn = 1'b0;
        frame();
        checks++;
        if ({bus0.main_x, bus0.sec_x} !== {10'd62, 10'd418}) begin
            failures++;
            $display("FAIL step_one got main_x=%0d sec_x=%0d exp 62 418", bus0.main_x, bus0.sec_x);
        end
        frame();
        checks++;
        if (bus0.main_x !== 10'd62) begin
            failures++;
            $display("FAIL step_consumed got main_x=%0d exp=62", bus0.main_x);
        end
        run = 1'b1;
        @(negedge clk) step_btn = 1'b1;
        @(negedge clk) step_btn = 1'b0;
        frame();
        run = 1'b0;
        frame();
        checks++;
        if (bus0.main_x !== 10'd64) begin
            failures++;
            $display("FAIL step_ignored_in_run got main_x=%0d exp=64", bus0.main_x);
        end
    endtask

    task automatic test_swap();
        do_reset();
        run = 1'b1;
        @(negedge clk) begin frame_start = 1'b1; swap_req = 1'b1; end
        @(negedge clk) begin frame_start = 1'b0; swap_req = 1'b0; end
        repeat (2) @(negedge clk);
        checks++;
        if (bus0.main_on_top !== 1'b1) begin
            failures++;
            $display("FAIL swap_n3 got=%b exp=1", bus0.main_on_top);
        end
        @(negedge clk);
        checks++;
        if (bus0.main_on_top !== 1'b0) begin
            failures++;
            $display("FAIL swap_n4 got=%b exp=0", bus0.main_on_top);
        end
        repeat (2) begin
            @(negedge clk) swap_req = 1'b1;
            @(negedge clk) swap_req = 1'b0;
        end
        frame();
        checks++;
        if (bus0.main_on_top !== 1'b1) begin
            failures++;
            $display("FAIL swap_double got=%b exp=1", bus0.main_on_top);
        end
        // request lands in CHECK: deferred to the following update
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk) swap_req = 1'b1;
        @(negedge clk) swap_req = 1'b0;
        checks++;
        if (bus0.main_on_top !== 1'b1) begin
            failures++;
            $display("FAIL swap_in_check got=%b exp=1", bus0.main_on_top);
        end
        frame();
        checks++;
        if (bus0.main_on_top !== 1'b0) begin
            failures++;
            $display("FAIL swap_deferred got=%b exp=0", bus0.main_on_top);
        end
        run = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        run = 1'b1;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus0.main_x, bus0.sec_x, bus0.busy} !== {10'd62, 10'd418, 1'b0}) begin
            failures++;
            $display("FAIL b2b_ignored got main_x=%0d sec_x=%0d busy=%b exp 62 418 0",
                     bus0.main_x, bus0.sec_x, bus0.busy);
        end
        run = 1'b0;
    endtask

    task automatic test_overlap();
        do_reset();
        run = 1'b1;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_o.collide !== 1'b0) begin
            failures++;
            $display("FAIL ov_before_check got=%b exp=0", bus_o.collide);
        end
        @(negedge clk);
        checks++;
        if ({bus_o.collide, bus_o.hit_count} !== {1'b1, 8'd1}) begin
            failures++;
            $display("FAIL ov_first got col=%b hit=%0d exp 1 1", bus_o.collide, bus_o.hit_count);
        end
        checks++;
        if ({bus0.collide, bus0.hit_count} !== {1'b0, 8'd0}) begin
            failures++;
            $display("FAIL ov_apart got col=%b hit=%0d exp 0 0", bus0.collide, bus0.hit_count);
        end
        repeat (3) frame();
        checks++;
        if ({bus_o.collide, bus_o.hit_count} !== {1'b1, 8'd1}) begin
            failures++;
            $display("FAIL ov_held got col=%b hit=%0d exp 1 1", bus_o.collide, bus_o.hit_count);
        end
        checks++;
        if ({bus_o.main_x, bus_o.main_y, bus_o.sec_x, bus_o.sec_y} !== {10'd408, 10'd308, 10'd432, 10'd302}) begin
            failures++;
            $display("FAIL ov_no_dir_change got main=(%0d,%0d) sec=(%0d,%0d) exp (408,308) (432,302)",
                     bus_o.main_x, bus_o.main_y, bus_o.sec_x, bus_o.sec_y);
        end
        run = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        force dut_o.hit_q = 8'hFF;
        @(negedge clk);
        release dut_o.hit_q;
        @(negedge clk);
        checks++;
        if (bus_o.hit_count !== 8'd255) begin
            failures++;
            $display("FAIL sat_preload got=%0d exp=255", bus_o.hit_count);
        end
        run = 1'b1;
        frame();
        checks++;
        if ({bus_o.collide, bus_o.hit_count} !== {1'b1, 8'd255}) begin
            failures++;
            $display("FAIL sat_hold got col=%b hit=%0d exp 1 255", bus_o.collide, bus_o.hit_count);
        end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_update();
        test_wall_bounce();
        test_step();
        test_swap();
        test_back_to_back();
        test_overlap();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
